// File: rtl/temporizador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_pkg
// Brief    : Shared state encodings, defaults and channel indices for the
//            game event timer.
// Revision : 1.0
// ============================================================================
package temporizador_pkg;

    typedef enum logic [1:0] {
        PARADO  = 2'b00,
        RODANDO = 2'b01,
        PAUSADO = 2'b10
    } estado_t;

    localparam int W_PADRAO           = 64;
    localparam int MIN_PERIODO_PADRAO = 2;
    localparam int WP_PADRAO          = 8;

    localparam int NUM_CANAIS      = 3;
    localparam int CANAL_GERA      = 0;
    localparam int CANAL_MOVE_ASTE = 1;
    localparam int CANAL_MOVE_TIRO = 2;

endpackage
`default_nettype wire

// File: rtl/temporizador_eventos_jogo_canal.sv
`default_nettype none
// ============================================================================
// Module   : canal_temporizador
// Brief    : One periodic event channel: interval counter, held request with
//            acknowledge, and saturating missed-event counter.
// Revision : 1.0
// ============================================================================
module canal_temporizador
    import temporizador_pkg::*;
#(
    parameter int W           = W_PADRAO,
    parameter int MIN_PERIODO = MIN_PERIODO_PADRAO,
    parameter int WP          = WP_PADRAO
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          limpar,
    input  logic          contar,
    input  logic [W-1:0]  periodo,
    input  logic          ack,
    output logic          pedido,
    output logic [WP-1:0] perdas
);

    localparam logic [W-1:0]  c_min_periodo = W'(MIN_PERIODO);
    localparam logic [W-1:0]  c_um          = W'(1);
    localparam logic [WP-1:0] c_perdas_max  = '1;

    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_periodo;
    logic          r_pedido;
    logic [WP-1:0] r_perdas;

    logic [W-1:0]  w_periodo_efetivo;
    logic          w_expira;
    logic          w_overrun;

    assign w_periodo_efetivo = (periodo < c_min_periodo) ? c_min_periodo : periodo;
    assign w_expira          = contar && (r_cnt == (r_periodo - c_um));
    // An ack landing on the expiry edge consumes the old event, so nothing is lost.
    assign w_overrun         = w_expira && r_pedido && !ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_periodo <= c_min_periodo;
            r_pedido  <= 1'b0;
            r_perdas  <= '0;
        end else if (limpar) begin
            r_cnt     <= '0;
            r_periodo <= w_periodo_efetivo;
            r_pedido  <= 1'b0;
            r_perdas  <= '0;
        end else begin
            if (w_expira) begin
                r_cnt     <= '0;
                r_periodo <= w_periodo_efetivo;
            end else if (contar) begin
                r_cnt <= r_cnt + c_um;
            end

            if (w_expira) begin
                r_pedido <= 1'b1;
            end else if (ack && r_pedido) begin
                r_pedido <= 1'b0;
            end

            if (w_overrun && (r_perdas != c_perdas_max)) begin
                r_perdas <= r_perdas + 1'b1;
            end
        end
    end

    assign pedido = r_pedido;
    assign perdas = r_perdas;

endmodule
`default_nettype wire

// File: rtl/temporizador_eventos_jogo.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_eventos_jogo
// Brief    : Start/stop/pause control FSM driving three periodic event
//            channels (asteroid spawn, asteroid move, shot move).
// Revision : 1.0
// ============================================================================
module temporizador_eventos_jogo
    import temporizador_pkg::*;
#(
    parameter int W           = W_PADRAO,
    parameter int MIN_PERIODO = MIN_PERIODO_PADRAO,
    parameter int WP          = WP_PADRAO
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          parar,
    input  logic          pausa,
    input  logic [W-1:0]  tempo_gera_aste,
    input  logic [W-1:0]  tempo_move_aste,
    input  logic [W-1:0]  tempo_move_tiro,
    input  logic          ack_gera,
    input  logic          ack_move_aste,
    input  logic          ack_move_tiro,
    output logic          pedido_gera,
    output logic          pedido_move_aste,
    output logic          pedido_move_tiro,
    output logic [WP-1:0] perdas_gera,
    output logic [WP-1:0] perdas_move_aste,
    output logic [WP-1:0] perdas_move_tiro,
    output logic [1:0]    estado
);

    estado_t r_estado;
    estado_t w_estado_prox;
    logic    w_limpar;
    logic    w_contar;
    logic    w_forcar_ack;

    logic [W-1:0]            w_periodo [NUM_CANAIS];
    logic [NUM_CANAIS-1:0]   w_ack;
    logic [NUM_CANAIS-1:0]   w_pedido;
    logic [WP-1:0]           w_perdas  [NUM_CANAIS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= PARADO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Stopping must drop pending requests while leaving counters and losses
    // untouched; a forced ack does exactly that since no expiry can coincide.
    always_comb begin
        w_estado_prox = r_estado;
        w_limpar      = 1'b0;
        w_contar      = 1'b0;
        w_forcar_ack  = 1'b0;
        if (parar) begin
            w_estado_prox = PARADO;
            w_forcar_ack  = 1'b1;
        end else if (iniciar) begin
            w_estado_prox = RODANDO;
            w_limpar      = 1'b1;
        end else begin
            case (r_estado)
                RODANDO: begin
                    if (pausa) begin
                        w_estado_prox = PAUSADO;
                    end else begin
                        w_contar = 1'b1;
                    end
                end
                PAUSADO: begin
                    if (!pausa) begin
                        w_estado_prox = RODANDO;
                    end
                end
                default: begin
                    w_estado_prox = r_estado;
                end
            endcase
        end
    end

    assign w_periodo[CANAL_GERA]      = tempo_gera_aste;
    assign w_periodo[CANAL_MOVE_ASTE] = tempo_move_aste;
    assign w_periodo[CANAL_MOVE_TIRO] = tempo_move_tiro;

    assign w_ack[CANAL_GERA]      = ack_gera;
    assign w_ack[CANAL_MOVE_ASTE] = ack_move_aste;
    assign w_ack[CANAL_MOVE_TIRO] = ack_move_tiro;

    generate
        for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
            canal_temporizador #(
                .W           (W),
                .MIN_PERIODO (MIN_PERIODO),
                .WP          (WP)
            ) u_canal (
                .clock   (clock),
                .reset   (reset),
                .limpar  (w_limpar),
                .contar  (w_contar),
                .periodo (w_periodo[i]),
                .ack     (w_ack[i] | w_forcar_ack),
                .pedido  (w_pedido[i]),
                .perdas  (w_perdas[i])
            );
        end
    endgenerate

    assign pedido_gera      = w_pedido[CANAL_GERA];
    assign pedido_move_aste = w_pedido[CANAL_MOVE_ASTE];
    assign pedido_move_tiro = w_pedido[CANAL_MOVE_TIRO];
    assign perdas_gera      = w_perdas[CANAL_GERA];
    assign perdas_move_aste = w_perdas[CANAL_MOVE_ASTE];
    assign perdas_move_tiro = w_perdas[CANAL_MOVE_TIRO];
    assign estado           = r_estado;

endmodule
`default_nettype wire
